scaler_rom_coe: RTL and testbench

SCALER_ROM_COE -- requirements
Module: scaler_rom_coe

---
 rtl/scaler_rom_coe.sv | 107 ++++++++++
 tb/tb_scaler_rom_coe.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/scaler_rom_coe.sv
// Coefficient ROM for 4-tap cubic convolution (Keys kernel, a = -0.5).
// 1024 phases are stored, with four unsigned tap weights per phase, all read
// together. Taps 0 and 3 hold magnitudes that the consumer subtracts. Taps 1
// and 2 are added. The table is built at elaboration with exact integer
// arithmetic. The read is registered, so latency is one cycle, and a
// synchronous reset clears the outputs.
module scaler_rom_coe #(
  parameter int COE_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [9:0]           addr,
  output logic [COE_WIDTH-1:0] rom0_do,
  output logic [COE_WIDTH-1:0] rom1_do,
  output logic [COE_WIDTH-1:0] rom2_do,
  output logic [COE_WIDTH-1:0] rom3_do
);

  localparam int DEPTH   = 1024;
  localparam int ENTRY_W = 4 * COE_WIDTH;

  // With t = a/1024, each weight is written as num / (2 * 1024^3), where num
  // is an integer polynomial in a. Scaling by 2^(COE_WIDTH-1) therefore gives
  // num * 2^(COE_WIDTH-2) / 2^30. Rounding half-up becomes
  // "add 2^29 then shift right by 30", which avoids any real arithmetic.
  function automatic logic [COE_WIDTH-1:0] scale_round(input longint num);
    longint scaled;
    longint max_val;
    max_val = (longint'(1) << COE_WIDTH) - 1;
    scaled  = (num * (longint'(1) << (COE_WIDTH - 2)) + (longint'(1) << 29)) >>> 30;
    if (scaled > max_val) begin
      scaled = max_val;
    end
    return scaled[COE_WIDTH-1:0];
  endfunction

  // Each packed entry holds {c3, c2, c1, c0}. Every numerator is
  // non-negative on [0, 1), so all four stored weights are unsigned.
  function automatic logic [ENTRY_W-1:0] coe_entry(input int a);
    longint n;
    longint x;
    longint x2;
    longint x3;
    logic [COE_WIDTH-1:0] c0;
    logic [COE_WIDTH-1:0] c1;
    logic [COE_WIDTH-1:0] c2;
    logic [COE_WIDTH-1:0] c3;
    n  = 1024;
    x  = longint'(a);
    x2 = x * x;
    x3 = x2 * x;
    c0 = scale_round(x * (n - x) * (n - x));
    c1 = scale_round(3 * x3 - 5 * x2 * n + 2 * n * n * n);
    c2 = scale_round(-3 * x3 + 4 * x2 * n + x * n * n);
    c3 = scale_round(x2 * (n - x));
    return {c3, c2, c1, c0};
  endfunction

  logic [ENTRY_W-1:0] rom_table [DEPTH];

  // Each table row is an elaboration-time constant, so the array folds into
  // a pure ROM.
  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    localparam logic [ENTRY_W-1:0] ENTRY = coe_entry(i);
    assign rom_table[i] = ENTRY;
  end

  logic [ENTRY_W-1:0]   entry;
  logic [COE_WIDTH-1:0] rom0_d;
  logic [COE_WIDTH-1:0] rom1_d;
  logic [COE_WIDTH-1:0] rom2_d;
  logic [COE_WIDTH-1:0] rom3_d;
  logic [COE_WIDTH-1:0] rom0_q;
  logic [COE_WIDTH-1:0] rom1_q;
  logic [COE_WIDTH-1:0] rom2_q;
  logic [COE_WIDTH-1:0] rom3_q;

  // Select the next output word: reset takes priority and forces zeros.
  // Otherwise the row chosen by addr is split into the four taps.
  always_comb begin
    entry  = rom_table[addr];
    rom0_d = '0;
    rom1_d = '0;
    rom2_d = '0;
    rom3_d = '0;
    if (!rst) begin
      rom0_d = entry[COE_WIDTH-1:0];
      rom1_d = entry[2*COE_WIDTH-1:COE_WIDTH];
      rom2_d = entry[3*COE_WIDTH-1:2*COE_WIDTH];
      rom3_d = entry[4*COE_WIDTH-1:3*COE_WIDTH];
    end
  end

  // Output register: a read happens on every rising edge.
  always_ff @(posedge clk) begin
    rom0_q <= rom0_d;
    rom1_q <= rom1_d;
    rom2_q <= rom2_d;
    rom3_q <= rom3_d;
  end

  assign rom0_do = rom0_q;
  assign rom1_do = rom1_q;
  assign rom2_do = rom2_q;
  assign rom3_do = rom3_q;

endmodule

// File: tb/tb_scaler_rom_coe.sv
// Self-checking bench for scaler_rom_coe. It drives a default-width instance
// and a 12-bit instance from the same addr/rst stimulus.
module tb_scaler_rom_coe;

  typedef struct packed {
    logic [9:0]  a;
    logic        r;
    logic [39:0] e10;
    logic [47:0] e12;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  addr = '0;
  logic [9:0]  r0_10, r1_10, r2_10, r3_10;
  logic [11:0] r0_12, r1_12, r2_12, r3_12;

  int   tests = 0;
  int   fails = 0;
  vec_t sb[$];
  int   sw0 [1024];
  int   sw1 [1024];
  int   sw2 [1024];
  int   sw3 [1024];

  always #5 clk = ~clk;

  scaler_rom_coe #(.COE_WIDTH(10)) dut10 (
    .clk(clk), .rst(rst), .addr(addr),
    .rom0_do(r0_10), .rom1_do(r1_10), .rom2_do(r2_10), .rom3_do(r3_10)
  );

  scaler_rom_coe #(.COE_WIDTH(12)) dut12 (
    .clk(clk), .rst(rst), .addr(addr),
    .rom0_do(r0_12), .rom1_do(r1_12), .rom2_do(r2_12), .rom3_do(r3_12)
  );

  // Reference weight from the real-valued kernel. t = a/1024 is dyadic, so
  // double precision evaluates it exactly.
  function automatic int model_coe(int k, int a, int w);
    real t, c, s;
    int  v, mx;
    t = real'(a) / 1024.0;
    case (k)
      0:       c = 0.5 * t * (1.0 - t) * (1.0 - t);
      1:       c = 1.5 * t * t * t - 2.5 * t * t + 1.0;
      2:       c = -1.5 * t * t * t + 2.0 * t * t + 0.5 * t;
      default: c = 0.5 * t * t * (1.0 - t);
    endcase
    s  = c * (2.0 ** (w - 1));
    v  = int'($floor(s + 0.5));
    mx = (1 << w) - 1;
    if (v > mx) v = mx;
    return v;
  endfunction

  function automatic vec_t model_vec(int a, logic r);
    vec_t v;
    v.a = 10'(a);
    v.r = r;
    if (r) begin
      v.e10 = '0;
      v.e12 = '0;
    end else begin
      v.e10 = {10'(model_coe(0, a, 10)), 10'(model_coe(1, a, 10)),
               10'(model_coe(2, a, 10)), 10'(model_coe(3, a, 10))};
      v.e12 = {12'(model_coe(0, a, 12)), 12'(model_coe(1, a, 12)),
               12'(model_coe(2, a, 12)), 12'(model_coe(3, a, 12))};
    end
    return v;
  endfunction

  // Pop the oldest expectation and compare both instances against it.
  task automatic check_output(input string name);
    vec_t        e;
    logic [39:0] g10;
    logic [47:0] g12;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s: scoreboard empty", name);
      return;
    end
    e   = sb.pop_front();
    g10 = {r0_10, r1_10, r2_10, r3_10};
    g12 = {r0_12, r1_12, r2_12, r3_12};
    tests++;
    if (g10 !== e.e10) begin
      fails++;
      $display("[TB] FAIL %s w10 addr=%0d: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
               name, e.a, r0_10, r1_10, r2_10, r3_10,
               e.e10[39:30], e.e10[29:20], e.e10[19:10], e.e10[9:0]);
    end
    tests++;
    if (g12 !== e.e12) begin
      fails++;
      $display("[TB] FAIL %s w12 addr=%0d: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
               name, e.a, r0_12, r1_12, r2_12, r3_12,
               e.e12[47:36], e.e12[35:24], e.e12[23:12], e.e12[11:0]);
    end
  endtask

  // Drive one addr/rst pair, record its expectation, then step one clock and
  // check. The outputs are sampled 1 time unit after the edge.
  task automatic apply_stimulus(input vec_t v, input string name);
    addr = v.a;
    rst  = v.r;
    sb.push_back(v);
    @(posedge clk);
    #1;
    check_output(name);
  endtask

  initial begin
    vec_t vectors [4];
    vec_t v;
    int   gain, d;

    vectors[0] = '{a: 10'd0,   r: 1'b0, e10: {10'd0,  10'd512, 10'd0,   10'd0},
                   e12: {12'd0,   12'd2048, 12'd0,    12'd0}};
    vectors[1] = '{a: 10'd512, r: 1'b0, e10: {10'd32, 10'd288, 10'd288, 10'd32},
                   e12: {12'd128, 12'd1152, 12'd1152, 12'd128}};
    vectors[2] = '{a: 10'd256, r: 1'b0, e10: {10'd36, 10'd444, 10'd116, 10'd12},
                   e12: {12'd144, 12'd1776, 12'd464,  12'd48}};
    vectors[3] = '{a: 10'd768, r: 1'b0, e10: {10'd12, 10'd116, 10'd444, 10'd36},
                   e12: {12'd48,  12'd464,  12'd1776, 12'd144}};

    // Reset state
    @(posedge clk);
    #1;
    apply_stimulus(model_vec(0, 1'b1), "reset");
    apply_stimulus(model_vec(700, 1'b1), "reset_nonzero_addr");

    // Known-value vectors
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(vectors[i], "vector");
    end

    // Full back-to-back sweep with gain and symmetry checks
    for (int a = 0; a < 1024; a++) begin
      apply_stimulus(model_vec(a, 1'b0), "sweep");
      sw0[a] = int'(r0_10);
      sw1[a] = int'(r1_10);
      sw2[a] = int'(r2_10);
      sw3[a] = int'(r3_10);
      gain = sw1[a] + sw2[a] - sw0[a] - sw3[a];
      tests++;
      if (gain < 510 || gain > 514) begin
        fails++;
        $display("[TB] FAIL unity_gain addr=%0d: got %0d want 512+-2", a, gain);
      end
    end
    for (int a = 1; a < 1024; a++) begin
      d = sw0[a] - sw3[1024 - a];
      tests++;
      if (d < -1 || d > 1) begin
        fails++;
        $display("[TB] FAIL symmetry03 addr=%0d: got %0d vs %0d", a, sw0[a], sw3[1024 - a]);
      end
      d = sw1[a] - sw2[1024 - a];
      tests++;
      if (d < -1 || d > 1) begin
        fails++;
        $display("[TB] FAIL symmetry12 addr=%0d: got %0d vs %0d", a, sw1[a], sw2[1024 - a]);
      end
    end

    // Mid-stream reset at addr 512, then recovery on the first free edge
    apply_stimulus(model_vec(100, 1'b0), "pre_reset");
    apply_stimulus(model_vec(512, 1'b1), "mid_reset_1");
    apply_stimulus(model_vec(512, 1'b1), "mid_reset_2");
    apply_stimulus(vectors[1], "post_reset");
    apply_stimulus(model_vec(1023, 1'b0), "top_addr");
    apply_stimulus(vectors[0], "back_to_zero");

    v = model_vec(1, 1'b0);
    apply_stimulus(v, "addr_one");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
